miriscv_data_arbiter: RTL and testbench
=======================================

// Module: miriscv_data_arbiter
// PURPOSE
//  Shares the single data port of the instruction/data RAM between NREQ requesters
//  (requester 0 = core LSU, requester 1 = external loader/DMA). One access per cycle.
//  Round-robin arbitration, with an optional bounded lock for bursts.
//  Registered read response one cycle after the grant. Sits between requesters and RAM data port.
// PARAMETERS
//  NREQ      2    number of requesters, legal 2..4
//  MAX_LOCK  8    max consecutive grants to a locking owner before a forced release, >=1
// PORTS
//  clk_i      in   1             system clock
//  rst_i      in   1             asynchronous reset, active-high
//  req_i      in   NREQ          access request per requester
//  we_i       in   NREQ          1 = write, 0 = read
//  be_i       in   NREQ x 4      byte enables (writes only)
//  addr_i     in   NREQ x 32     byte address
//  wdata_i    in   NREQ x 32     write data
//  lock_i     in   NREQ          request to keep ownership for the next access
//  gnt_o      out  NREQ          one-hot grant, same cycle as access
//  rvalid_o   out  NREQ          one-hot response, cycle after grant
//  rdata_o    out  32            read data, valid with rvalid_o
//  ram_req_o  out  1             RAM data request
//  ram_we_o   out  1             RAM write enable
//  ram_be_o   out  4             RAM byte enables
//  ram_addr_o out  32            RAM address
//  ram_wdata_o out 32            RAM write data
//  ram_rdata_i in  32            RAM read data, combinational from ram_addr_o
// BEHAVIOUR
//  Reset: gnt_o=0, rvalid_o=0, rdata_o=0, ram_req_o=0, ram_we_o=0. Pointer ptr=0, owner=none, lock_cnt=0.
//    While rst_i is high, gnt_o and ram_req_o are forced to 0.
//  Grant is combinational, at most one bit set. ram_* mirror the granted requester's inputs.
//    ram_req_o = |gnt_o. With no grant, ram_we_o=0 and ram_be_o=0.
//  Requester rule: hold req and all fields stable until gnt is seen. Deassert or change after the gnt cycle.
//  Priority:
//    1) If owner is valid, req_i[owner]=1 and lock_cnt<MAX_LOCK: grant owner.
//    2) Else: first requesting index at or after ptr, wrapping modulo NREQ.
//  On any grant to i: ptr<=(i+1)%NREQ.
//    If lock_i[i]=1: owner<=i and lock_cnt<=lock_cnt+1 (lock_cnt<=1 if i was not owner).
//    Else: owner<=none and lock_cnt<=0.
//  Forced release: when lock_cnt==MAX_LOCK, owner is cleared and lock_cnt<=0, and rule 2 applies that cycle.
//    If the former owner is the only requester, it is granted again and its lock restarts at lock_cnt=1.
//  Owner drops req: owner<=none and lock_cnt<=0 on that edge.
//  Response: every granted access sets rvalid_o[i]=1 for exactly the next cycle, writes included.
//    Read: rdata_o<=ram_rdata_i, sampled on the grant edge.
//    Write: rdata_o<=0.
//    rdata_o holds its value when rvalid_o=0.
//  Throughput 1 access/cycle. Back-to-back grants give back-to-back rvalid.
//    The gnt of cycle n+1 and the rvalid of cycle n coexist.
//  A write with be=0 is granted and acked, and writes nothing.
//  Reset mid-operation clears a pending rvalid immediately (asynchronous); no response follows.
//  Addresses pass through unmodified; alignment is the RAM's concern.
// STRUCTURE
//  Package miriscv_mem_pkg:
//    typedef struct packed {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} mem_req_t
//    localparams REQ_CORE=0, REQ_EXT=1, NREQ_MAX=4
//  Sub-module miriscv_rr_picker: combinational; inputs req vector and ptr; outputs one-hot pick.
//  Top level holds ptr, owner, lock_cnt, rvalid and rdata registers, plus the RAM-side mux.
// TESTING
//  Only req0 read addr 0x10; RAM word 0xDEADBEEF -> gnt_o=01 same cycle; next cycle rvalid_o=01, rdata_o=0xDEADBEEF.
//  req0 and req1 held high 4 cycles, ptr=0 at start -> grants 01,10,01,10; rvalid trails by 1 cycle.
//  req1 with lock_i=1 and req0 both held, MAX_LOCK=8 -> 8 grants to 1, then 1 grant to 0, then owner 1 re-locks.
//  req1 write be=0101 wdata=0xAABBCCDD addr 0x20, then req0 read 0x20 -> rdata_o=0x00BB00DD (RAM init 0).
//  rst_i asserted in the cycle after a grant -> rvalid_o=0 immediately; ptr=0; no response after release.
//  No requests -> ram_req_o=0, ram_we_o=0, gnt_o=0, rdata_o unchanged.

Source files
------------

// File: rtl/miriscv_mem_pkg.sv
// miriscv_mem_pkg: shared request record and requester indices for the data-port arbiter
package miriscv_mem_pkg;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  localparam int REQ_CORE = 0;
  localparam int REQ_EXT  = 1;
  localparam int NREQ_MAX = 4;

endpackage

// File: rtl/miriscv_rr_picker.sv
// miriscv_rr_picker: one-hot pick of the first requester at or after ptr_i, wrapping
//   req_i  : request vector
//   ptr_i  : index with the highest priority this cycle
//   pick_o : one-hot pick, zero when nobody requests
module miriscv_rr_picker #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] pick_o
);
  // Walk from the far end back to ptr so the nearest requester is written last and wins.
  always_comb begin
    pick_o = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NREQ]) pick_o = NREQ'(1) << ((int'(ptr_i) + k) % NREQ);
    end
  end
endmodule

// File: rtl/miriscv_data_arbiter.sv
// miriscv_data_arbiter: round-robin arbiter with bounded locking for the shared RAM data port
//   clk_i/rst_i            : clock, asynchronous active-high reset
//   req_i/we_i/be_i/addr_i/wdata_i/lock_i : per-requester access and lock request
//   gnt_o                  : one-hot grant, same cycle as the RAM access
//   rvalid_o/rdata_o       : one-hot response and read data, one cycle after the grant
//   ram_*                  : RAM data port, mirrors the granted requester
module miriscv_data_arbiter
  import miriscv_mem_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MAX_LOCK = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       we_i,
  input  logic [NREQ-1:0][3:0]  be_i,
  input  logic [NREQ-1:0][31:0] addr_i,
  input  logic [NREQ-1:0][31:0] wdata_i,
  input  logic [NREQ-1:0]       lock_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  ram_req_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d, gidx;
  logic            owner_vld_q, owner_vld_d, hold, any;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d, pick;
  logic [31:0]     rdata_q, rdata_d;
  mem_req_t        reqs [NREQ];
  mem_req_t        sel;
  miriscv_rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .pick_o(pick)
  );
  // The owner keeps the port until its budget is spent; at MAX_LOCK it falls back to round-robin.
  always_comb begin
    for (int i = 0; i < NREQ; i++) reqs[i] = '{we: we_i[i], be: be_i[i], addr: addr_i[i], wdata: wdata_i[i]};
    hold  = owner_vld_q && req_i[owner_q] && (lock_cnt_q < CW'(MAX_LOCK));
    gnt_o = rst_i ? '0 : hold ? NREQ'(1) << owner_q : pick;
    any   = |gnt_o;
    gidx  = '0;
    for (int i = 0; i < NREQ; i++) if (gnt_o[i]) gidx = PW'(i);
    sel   = any ? reqs[gidx] : '0;
  end
  assign ram_req_o   = any;
  assign ram_we_o    = sel.we;
  assign ram_be_o    = sel.be;
  assign ram_addr_o  = sel.addr;
  assign ram_wdata_o = sel.wdata;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  // A lock taken via forced release or by a new owner restarts at 1; only a held owner counts up.
  always_comb begin
    ptr_d       = any ? PW'((int'(gidx) + 1) % NREQ) : ptr_q;
    owner_vld_d = any && lock_i[gidx];
    owner_d     = owner_vld_d ? gidx : '0;
    lock_cnt_d  = !owner_vld_d ? '0 : hold ? lock_cnt_q + CW'(1) : CW'(1);
    rvalid_d    = gnt_o;
    rdata_d     = any ? (sel.we ? '0 : ram_rdata_i) : rdata_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      lock_cnt_q  <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      lock_cnt_q  <= lock_cnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// tb_miriscv_data_arbiter: scoreboard bench for the data-port arbiter with a behavioural RAM
module tb_miriscv_data_arbiter;
  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       req_i, we_i, lock_i;
  logic [1:0][3:0]  be_i;
  logic [1:0][31:0] addr_i, wdata_i;
  logic [1:0]       gnt_o, rvalid_o;
  logic [31:0]      rdata_o, ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic             ram_req_o, ram_we_o;
  logic [3:0]       ram_be_o;
  logic [31:0]      ram [0:255];
  logic [31:0]      exp_mem [0:255];
  logic [31:0]      exp_rdata;
  logic [1:0]       last_gnt;
  int               m_ptr, m_own, m_cnt;
  int               n_chk = 0, n_err = 0;
  typedef struct {logic [1:0] v; logic [31:0] d;} rsp_t;
  rsp_t             sb [$];
  always #5 clk_i = ~clk_i;
  miriscv_data_arbiter #(.NREQ(2), .MAX_LOCK(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .lock_i(lock_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .ram_req_o(ram_req_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i)
  );
  assign ram_rdata_i = ram[ram_addr_o[9:2]];
  always @(posedge clk_i)
    if (ram_req_o && ram_we_o)
      for (int b = 0; b < 4; b++) if (ram_be_o[b]) ram[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // Inputs are set at the negedge before calling; checks the grant, then the response after the edge.
  task cycle();
    int   g;
    logic h;
    rsp_t r;
    #1;
    g = -1;
    h = m_own >= 0 && req_i[m_own] && m_cnt < 8;
    if (h) g = m_own;
    else for (int k = 0; k < 2; k++) if (g < 0 && req_i[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
    r.v = g < 0 ? 2'b00 : 2'b01 << g;
    last_gnt = r.v;
    check("gnt", 32'(gnt_o), 32'(r.v));
    check("ram_req", 32'(ram_req_o), 32'(g >= 0));
    if (g >= 0) begin
      check("ram_addr", ram_addr_o, addr_i[g]);
      check("ram_we", 32'(ram_we_o), 32'(we_i[g]));
      check("ram_be", 32'(ram_be_o), 32'(be_i[g]));
      if (we_i[g]) begin
        check("ram_wdata", ram_wdata_o, wdata_i[g]);
        for (int b = 0; b < 4; b++) if (be_i[g][b]) exp_mem[addr_i[g][9:2]][8*b +: 8] = wdata_i[g][8*b +: 8];
        exp_rdata = 32'h0;
      end else exp_rdata = exp_mem[addr_i[g][9:2]];
      m_cnt = lock_i[g] ? (h ? m_cnt + 1 : 1) : 0;
      m_own = lock_i[g] ? g : -1;
      m_ptr = (g + 1) % 2;
    end else begin
      check("idle_we", 32'(ram_we_o), 32'h0);
      check("idle_be", 32'(ram_be_o), 32'h0);
      m_own = -1;
      m_cnt = 0;
    end
    r.d = exp_rdata;
    sb.push_back(r);
    @(posedge clk_i);
    #1;
    r = sb.pop_front();
    check("rvalid", 32'(rvalid_o), 32'(r.v));
    check("rdata", rdata_o, r.d);
    @(negedge clk_i);
  endtask
  task drive(input int i, input logic rq, input logic we, input logic [3:0] be,
             input logic [31:0] addr, input logic [31:0] wd, input logic lk);
    req_i[i] = rq; we_i[i] = we; be_i[i] = be; addr_i[i] = addr; wdata_i[i] = wd; lock_i[i] = lk;
  endtask
  task model_reset();
    m_ptr = 0; m_own = -1; m_cnt = 0; exp_rdata = 32'h0; sb.delete();
  endtask
  initial begin
    logic [7:0]  seq;
    logic [31:0] hold_val;
    int          n1;
    for (int i = 0; i < 256; i++) begin ram[i] = 32'h0; exp_mem[i] = 32'h0; end
    ram[4] = 32'hDEADBEEF; exp_mem[4] = 32'hDEADBEEF;
    rst_i = 1'b1;
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 1'b0);
    model_reset();
    @(posedge clk_i); #1;
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_ram_req", 32'(ram_req_o), 32'h0);
    check("rst_ram_we", 32'(ram_we_o), 32'h0);
    check("rst_rvalid", 32'(rvalid_o), 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    seq = '0;
    for (int n = 0; n < 4; n++) begin cycle(); seq = {seq[5:0], last_gnt}; end
    check("rr_seq", 32'(seq), 32'h66);
    req_i = 2'b00; cycle();
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    cycle();
    check("deadbeef", rdata_o, 32'hDEADBEEF);
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 1'b1);
    n1 = 0;
    for (int n = 0; n < 8; n++) begin cycle(); n1 += int'(last_gnt == 2'b10); end
    check("lock_run", 32'(n1), 32'd8);
    cycle(); check("lock_release", 32'(last_gnt), 32'h1);
    cycle(); check("lock_relock", 32'(last_gnt), 32'h2);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b0);
    cycle();
    check("wr_rdata", rdata_o, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    drive(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
    cycle();
    check("be_merge", rdata_o, 32'h00BB00DD);
    hold_val = rdata_o;
    drive(1, 1'b1, 1'b1, 4'b0000, 32'h10, 32'h12345678, 1'b0);
    req_i[0] = 1'b0;
    cycle();
    req_i = 2'b00;
    for (int n = 0; n < 3; n++) cycle();
    check("idle_hold", rdata_o, 32'h0);
    check("be0_nowrite", ram[4], 32'hDEADBEEF);
    drive(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
    cycle();
    check("pre_rst_rvalid", 32'(rvalid_o), 32'h1);
    check("pre_rst_rdata", rdata_o, hold_val);
    rst_i = 1'b1;
    #1;
    check("async_rvalid", 32'(rvalid_o), 32'h0);
    check("async_gnt", 32'(gnt_o), 32'h0);
    check("async_rdata", rdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    req_i = 2'b00;
    model_reset();
    cycle(); cycle();
    req_i = 2'b11;
    cycle();
    check("ptr_after_rst", 32'(last_gnt), 32'h1);
    req_i = 2'b00;
    cycle();
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++)
        if (!req_i[r] && $urandom_range(1, 0) == 1)
          drive(r, 1'b1, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                32'($urandom_range(63, 0)) << 2, $urandom, 1'($urandom_range(3, 0) != 0));
      cycle();
      req_i = req_i & ~last_gnt;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
